ppi_bus_master: RTL and testbench

PPI_BUS_MASTER -- requirements
Module: ppi_bus_master

---
 rtl/ppi_pkg.sv | 36 +++
 rtl/ppi_bus_master_timer.sv | 27 ++
 rtl/ppi_bus_master.sv | 169 ++++++++++++++++
 tb/tb_ppi_bus_master.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppi_pkg.sv
// ppi_pkg: shared bus-master states, PPI register addresses and default bus timing
package ppi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP,
        RECOV
    } ppi_state_t;

    localparam logic [1:0] PORT_A = 2'b00;
    localparam logic [1:0] PORT_B = 2'b01;
    localparam logic [1:0] PORT_C = 2'b10;
    localparam logic [1:0] CTRL   = 2'b11;

    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_PULSE_CYC = 2;
    localparam int DEF_HOLD_CYC  = 1;
    localparam int DEF_RECOV_CYC = 1;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int ab;
        int cd;
        ab = (a > b) ? a : b;
        cd = (c > d) ? c : d;
        return (ab > cd) ? ab : cd;
    endfunction

    // the timer holds remaining-cycles minus one, so the largest load is max_cyc-1
    function automatic int cnt_width(input int max_cyc);
        return (max_cyc > 1) ? $clog2(max_cyc) : 1;
    endfunction

endpackage

// File: rtl/ppi_bus_master_timer.sv
// ppi_cycle_timer: per-phase down counter, reloaded on each state entry, saturating at zero
module ppi_cycle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // reload on phase entry, otherwise count down and stop at zero (never wraps)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/ppi_bus_master.sv
// ppi_bus_master: valid/ready host port to 8255-style PPI bus cycles with programmable timing
module ppi_bus_master
    import ppi_pkg::*;
#(
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int RECOV_CYC = DEF_RECOV_CYC
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       cs,
    output logic       read,
    output logic       write,
    output logic [1:0] A_out,
    inout  wire  [7:0] D
);

    localparam int CW = cnt_width(max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, RECOV_CYC));
    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] LD_RECOV = CW'((RECOV_CYC > 0) ? RECOV_CYC - 1 : 0);

    ppi_state_t    r_state;
    ppi_state_t    w_next;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_done;
    logic          w_accept;
    logic          w_write_next;
    logic          w_bus_next;
    logic          r_write;
    logic [1:0]    r_addr;
    logic [7:0]    r_wdata;
    logic [7:0]    r_rdata;
    logic          r_cs;
    logic          r_rd;
    logic          r_wr;
    logic          r_drive;

    ppi_cycle_timer #(
        .W(CW)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    assign w_accept     = req_valid && req_ready;
    assign w_write_next = (r_state == IDLE) ? req_write : r_write;
    assign w_bus_next   = w_next inside {SETUP, STROBE, HOLD};

    // state register; reset aborts any bus cycle in flight without a response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state and phase-timer reload; every phase entry reloads the timer
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next     = SETUP;
                    w_load     = 1'b1;
                    w_load_val = LD_SETUP;
                end
            end
            SETUP: begin
                if (w_done) begin
                    w_next     = STROBE;
                    w_load     = 1'b1;
                    w_load_val = LD_PULSE;
                end
            end
            STROBE: begin
                if (w_done) begin
                    w_next     = HOLD;
                    w_load     = 1'b1;
                    w_load_val = LD_HOLD;
                end
            end
            HOLD: begin
                if (w_done) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next     = (RECOV_CYC == 0) ? IDLE : RECOV;
                    w_load     = 1'b1;
                    w_load_val = LD_RECOV;
                end
            end
            RECOV: begin
                if (w_done) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // latch the transaction on acceptance; it stays put for the whole bus cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write <= 1'b0;
            r_addr  <= 2'b00;
            r_wdata <= 8'h00;
        end else if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // response data: cleared on acceptance, sampled from D on the edge where RD rises
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= 8'h00;
        end else if (w_accept) begin
            r_rdata <= 8'h00;
        end else if (r_state == STROBE && w_done && !r_write) begin
            r_rdata <= D;
        end
    end

    // bus pins are registered from the state being entered so they switch glitch-free
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs    <= 1'b1;
            r_rd    <= 1'b1;
            r_wr    <= 1'b1;
            r_drive <= 1'b0;
        end else begin
            r_cs    <= !w_bus_next;
            r_rd    <= !(w_next == STROBE && !w_write_next);
            r_wr    <= !(w_next == STROBE && w_write_next);
            r_drive <= w_bus_next && w_write_next;
        end
    end

    assign req_ready = reset_n && (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign cs        = r_cs;
    assign read      = r_rd;
    assign write     = r_wr;
    assign A_out     = r_addr;
    assign D         = r_drive ? r_wdata : 8'hzz;

endmodule

// File: tb/tb_ppi_bus_master.sv
// tb_ppi_bus_master: scoreboard bench for default, 1/1/1/0 and 3/4/2/2 timing variants
`timescale 1ns/1ps
module tb_ppi_bus_master;
    import ppi_pkg::*;

    localparam int NI = 3;
    localparam int S_C [NI] = '{1, 1, 3};
    localparam int P_C [NI] = '{2, 1, 4};
    localparam int H_C [NI] = '{1, 1, 2};
    localparam int R_C [NI] = '{1, 0, 2};
    localparam logic [7:0] PARK = 8'h3C;

    typedef struct packed {
        int wait_acc;
        int lat;
        int cs_n;
        int cs_first;
        int wr_n;
        int wr_first;
        int rd_n;
        int rd_first;
        int recov;
        logic timeout;
        logic a_bad;
        logic d_bad;
        logic proto_bad;
        logic stall_bad;
        logic [7:0] rdata;
        logic [7:0] d_resp;
    } meas_t;

    logic clk;
    logic reset_n;
    logic req_valid;
    logic req_write;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic rsp_ready;
    logic [7:0] rd_val;
    int sel;
    int checks;
    int errors;
    logic [7:0] sb [$];

    logic rdy_a, rv_a, cs_a, rdn_a, wrn_a;
    logic rdy_b, rv_b, cs_b, rdn_b, wrn_b;
    logic rdy_c, rv_c, cs_c, rdn_c, wrn_c;
    logic [7:0] rdat_a, rdat_b, rdat_c;
    logic [1:0] ao_a, ao_b, ao_c;
    wire [7:0] d_a, d_b, d_c;

    logic cur_rdy, cur_rv, cur_cs, cur_rd, cur_wr;
    logic [7:0] cur_rdata, cur_d;
    logic [1:0] cur_ao;

    // PPI model: returns rd_val while RD is low; parks a known pattern while CS is high
    assign d_a = !rdn_a ? rd_val : (cs_a ? PARK : 8'hzz);
    assign d_b = !rdn_b ? rd_val : (cs_b ? PARK : 8'hzz);
    assign d_c = !rdn_c ? rd_val : (cs_c ? PARK : 8'hzz);

    ppi_bus_master u_a (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid && sel == 0), .req_ready(rdy_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_a),
        .rsp_ready(rsp_ready), .rsp_rdata(rdat_a), .cs(cs_a), .read(rdn_a), .write(wrn_a),
        .A_out(ao_a), .D(d_a)
    );

    ppi_bus_master #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .RECOV_CYC(0)) u_b (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid && sel == 1), .req_ready(rdy_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_b),
        .rsp_ready(rsp_ready), .rsp_rdata(rdat_b), .cs(cs_b), .read(rdn_b), .write(wrn_b),
        .A_out(ao_b), .D(d_b)
    );

    ppi_bus_master #(.SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2), .RECOV_CYC(2)) u_c (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid && sel == 2), .req_ready(rdy_c),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_c),
        .rsp_ready(rsp_ready), .rsp_rdata(rdat_c), .cs(cs_c), .read(rdn_c), .write(wrn_c),
        .A_out(ao_c), .D(d_c)
    );

    always_comb begin
        cur_rdy   = (sel == 0) ? rdy_a  : (sel == 1) ? rdy_b  : rdy_c;
        cur_rv    = (sel == 0) ? rv_a   : (sel == 1) ? rv_b   : rv_c;
        cur_cs    = (sel == 0) ? cs_a   : (sel == 1) ? cs_b   : cs_c;
        cur_rd    = (sel == 0) ? rdn_a  : (sel == 1) ? rdn_b  : rdn_c;
        cur_wr    = (sel == 0) ? wrn_a  : (sel == 1) ? wrn_b  : wrn_c;
        cur_rdata = (sel == 0) ? rdat_a : (sel == 1) ? rdat_b : rdat_c;
        cur_ao    = (sel == 0) ? ao_a   : (sel == 1) ? ao_b   : ao_c;
        cur_d     = (sel == 0) ? d_a    : (sel == 1) ? d_b    : d_c;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Drives one transaction on the selected instance and records what the bus did.
    // Called at a negedge; returns at the first negedge back in IDLE.
    task automatic run_txn(input logic w, input logic [1:0] ad, input logic [7:0] wd,
                           input int stall, output meas_t m);
        int cyc;
        logic [7:0] held;
        m = '0;
        req_write = w;
        req_addr  = ad;
        req_wdata = wd;
        rsp_ready = (stall == 0);
        sb.push_back(w ? 8'h00 : rd_val);
        req_valid = 1'b1;
        while (!cur_rdy && m.wait_acc < 50) begin
            @(negedge clk);
            m.wait_acc++;
        end
        if (!cur_rdy) begin
            m.timeout = 1'b1;
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!cur_rv && cyc < 60) begin
            if (!cur_cs) begin
                m.cs_n++;
                if (m.cs_first == 0) m.cs_first = cyc;
                if (cur_ao !== ad) m.a_bad = 1'b1;
                if (w && cur_d !== wd) m.d_bad = 1'b1;
            end
            if (!cur_wr) begin
                m.wr_n++;
                if (m.wr_first == 0) m.wr_first = cyc;
            end
            if (!cur_rd) begin
                m.rd_n++;
                if (m.rd_first == 0) m.rd_first = cyc;
            end
            if ((!cur_rd && !cur_wr) || ((!cur_rd || !cur_wr) && cur_cs)) m.proto_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (!cur_rv) begin
            m.timeout = 1'b1;
            rsp_ready = 1'b1;
            return;
        end
        m.lat    = cyc;
        m.rdata  = cur_rdata;
        m.d_resp = cur_d;
        held     = cur_rdata;
        for (int i = 0; i < stall; i++) begin
            if (!cur_rv || cur_rdata !== held || cur_rdy || !cur_cs || !cur_rd || !cur_wr) m.stall_bad = 1'b1;
            @(negedge clk);
        end
        if (!cur_rv || cur_rdata !== held) m.stall_bad = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        while (!cur_rdy && m.recov < 20) begin
            if (cur_rv || !cur_cs || !cur_rd || !cur_wr) m.proto_bad = 1'b1;
            @(negedge clk);
            m.recov++;
        end
        if (!cur_rdy) m.timeout = 1'b1;
    endtask

    task automatic test_reset;
        sel = 0;
        repeat (3) @(negedge clk);
        checks++; if (cs_a !== 1'b1) begin errors++; $display("FAIL rst_cs got=%b want=1", cs_a); end
        checks++; if (rdn_a !== 1'b1 || wrn_a !== 1'b1) begin errors++; $display("FAIL rst_strobes got=%b%b want=11", rdn_a, wrn_a); end
        checks++; if (ao_a !== 2'b00) begin errors++; $display("FAIL rst_addr got=%b want=00", ao_a); end
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL rst_req_ready got=%b want=0", rdy_a); end
        checks++; if (rv_a !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b want=0", rv_a); end
        checks++; if (rdat_a !== 8'h00) begin errors++; $display("FAIL rst_rdata got=%h want=00", rdat_a); end
        checks++; if (d_a !== PARK) begin errors++; $display("FAIL rst_d_released got=%h want=%h", d_a, PARK); end
        reset_n = 1'b1;
        #1;
        checks++; if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || rdy_c !== 1'b1) begin errors++; $display("FAIL rel_req_ready got=%b%b%b want=111", rdy_a, rdy_b, rdy_c); end
        @(negedge clk);
    endtask

    task automatic test_write_ctrl;
        meas_t m;
        logic [7:0] exp;
        sel = 0;
        run_txn(1'b1, CTRL, 8'h80, 0, m);
        exp = sb.pop_front();
        checks++; if (m.timeout !== 1'b0) begin errors++; $display("FAIL wr_timeout got=%b want=0", m.timeout); end
        checks++; if (m.cs_n != 4 || m.cs_first != 1) begin errors++; $display("FAIL wr_cs_low got=%0d@%0d want=4@1", m.cs_n, m.cs_first); end
        checks++; if (m.wr_n != 2 || m.wr_first != 2) begin errors++; $display("FAIL wr_strobe got=%0d@%0d want=2@2", m.wr_n, m.wr_first); end
        checks++; if (m.rd_n != 0) begin errors++; $display("FAIL wr_read_low got=%0d want=0", m.rd_n); end
        checks++; if (m.d_bad !== 1'b0 || m.a_bad !== 1'b0) begin errors++; $display("FAIL wr_bus_data got=%b%b want=00", m.d_bad, m.a_bad); end
        checks++; if (m.lat != 5) begin errors++; $display("FAIL wr_latency got=%0d want=5", m.lat); end
        checks++; if (m.rdata !== exp) begin errors++; $display("FAIL wr_rdata got=%h want=%h", m.rdata, exp); end
        checks++; if (m.d_resp !== PARK) begin errors++; $display("FAIL wr_d_released got=%h want=%h", m.d_resp, PARK); end
        checks++; if (m.recov != 1 || m.proto_bad !== 1'b0) begin errors++; $display("FAIL wr_recov got=%0d/%b want=1/0", m.recov, m.proto_bad); end
    endtask

    task automatic test_read_ports;
        logic [10:0] tbl [4];
        meas_t m;
        logic [7:0] exp;
        tbl = '{{1'b0, PORT_A, 8'hA5}, {1'b1, PORT_C, 8'h0F}, {1'b0, PORT_C, 8'h5A}, {1'b0, PORT_B, 8'hC6}};
        sel = 0;
        foreach (tbl[i]) begin
            rd_val = tbl[i][7:0];
            run_txn(tbl[i][10], tbl[i][9:8], tbl[i][7:0], 0, m);
            exp = sb.pop_front();
            checks++; if (m.rdata !== exp || m.timeout) begin errors++; $display("FAIL rd_data[%0d] got=%h want=%h", i, m.rdata, exp); end
            checks++; if (m.rd_n != (tbl[i][10] ? 0 : P_C[0]) || m.wr_n != (tbl[i][10] ? P_C[0] : 0)) begin errors++; $display("FAIL rd_strobes[%0d] got=rd%0d/wr%0d", i, m.rd_n, m.wr_n); end
            checks++; if (m.lat != S_C[0] + P_C[0] + H_C[0] + 1 || m.a_bad || m.d_bad || m.proto_bad) begin errors++; $display("FAIL rd_cycle[%0d] got=lat%0d flags%b%b%b want=lat%0d", i, m.lat, m.a_bad, m.d_bad, m.proto_bad, S_C[0] + P_C[0] + H_C[0] + 1); end
        end
    endtask

    task automatic test_backpressure;
        meas_t m;
        logic [7:0] exp;
        sel = 0;
        rd_val = 8'h3E;
        run_txn(1'b0, PORT_B, 8'h00, 6, m);
        exp = sb.pop_front();
        checks++; if (m.stall_bad !== 1'b0 || m.timeout) begin errors++; $display("FAIL bp_stable got=%b want=0", m.stall_bad); end
        checks++; if (m.rdata !== exp) begin errors++; $display("FAIL bp_rdata got=%h want=%h", m.rdata, exp); end
        checks++; if (m.recov != 1) begin errors++; $display("FAIL bp_recov got=%0d want=1", m.recov); end
    endtask

    task automatic test_back_to_back;
        meas_t m1;
        meas_t m2;
        logic [7:0] exp;
        sel = 1;
        run_txn(1'b1, PORT_A, 8'h11, 0, m1);
        rd_val = 8'h22;
        run_txn(1'b0, PORT_B, 8'h00, 0, m2);
        exp = sb.pop_front();
        checks++; if (m1.rdata !== exp || m1.timeout) begin errors++; $display("FAIL b2b_rdata0 got=%h want=%h", m1.rdata, exp); end
        exp = sb.pop_front();
        checks++; if (m2.rdata !== exp || m2.timeout) begin errors++; $display("FAIL b2b_rdata1 got=%h want=%h", m2.rdata, exp); end
        checks++; if (m1.recov != 0 || m2.wait_acc != 0 || m2.cs_first != 1) begin errors++; $display("FAIL b2b_gap got=recov%0d wait%0d cs@%0d want=0/0/1", m1.recov, m2.wait_acc, m2.cs_first); end
        checks++; if (m1.lat != 4 || m2.lat != 4) begin errors++; $display("FAIL b2b_latency got=%0d/%0d want=4/4", m1.lat, m2.lat); end
        checks++; if (m1.wr_n != 1 || m2.rd_n != 1 || m1.wr_first != 2 || m2.rd_first != 2) begin errors++; $display("FAIL b2b_strobe got=wr%0d@%0d rd%0d@%0d want=1@2", m1.wr_n, m1.wr_first, m2.rd_n, m2.rd_first); end
    endtask

    task automatic test_sweep;
        meas_t m;
        logic [7:0] exp;
        int tot;
        sel = 2;
        tot = S_C[2] + P_C[2] + H_C[2];
        run_txn(1'b1, PORT_C, 8'hA7, 0, m);
        exp = sb.pop_front();
        checks++; if (m.rdata !== exp || m.timeout) begin errors++; $display("FAIL sw_wr_rdata got=%h want=%h", m.rdata, exp); end
        checks++; if (m.lat != tot + 1 || m.cs_n != tot) begin errors++; $display("FAIL sw_wr_timing got=lat%0d cs%0d want=%0d/%0d", m.lat, m.cs_n, tot + 1, tot); end
        checks++; if (m.wr_n != P_C[2] || m.wr_first != S_C[2] + 1 || m.d_bad) begin errors++; $display("FAIL sw_wr_strobe got=%0d@%0d want=%0d@%0d", m.wr_n, m.wr_first, P_C[2], S_C[2] + 1); end
        checks++; if (m.recov != R_C[2]) begin errors++; $display("FAIL sw_recov got=%0d want=%0d", m.recov, R_C[2]); end
        rd_val = 8'h4B;
        run_txn(1'b0, CTRL, 8'h00, 0, m);
        exp = sb.pop_front();
        checks++; if (m.rdata !== exp || m.timeout) begin errors++; $display("FAIL sw_rd_rdata got=%h want=%h", m.rdata, exp); end
        checks++; if (m.rd_n != P_C[2] || m.rd_first != S_C[2] + 1 || m.lat != tot + 1 || m.proto_bad) begin errors++; $display("FAIL sw_rd_timing got=%0d@%0d lat%0d want=%0d@%0d lat%0d", m.rd_n, m.rd_first, m.lat, P_C[2], S_C[2] + 1, tot + 1); end
    endtask

    task automatic test_reset_mid;
        int n;
        logic seen;
        sel = 0;
        req_write = 1'b1;
        req_addr  = PORT_B;
        req_wdata = 8'hC3;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        n = 0;
        while (!cur_rdy && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (cur_wr && n < 20) begin @(negedge clk); n++; end
        checks++; if (cur_wr !== 1'b0) begin errors++; $display("FAIL rm_reach_strobe got=%b want=0", cur_wr); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (cur_cs !== 1'b1 || cur_wr !== 1'b1 || cur_rd !== 1'b1) begin errors++; $display("FAIL rm_pins got=cs%b wr%b rd%b want=111", cur_cs, cur_wr, cur_rd); end
        checks++; if (cur_d !== PARK) begin errors++; $display("FAIL rm_d_released got=%h want=%h", cur_d, PARK); end
        checks++; if (cur_rv !== 1'b0 || cur_rdy !== 1'b0 || cur_rdata !== 8'h00) begin errors++; $display("FAIL rm_handshake got=rv%b rdy%b %h want=0 0 00", cur_rv, cur_rdy, cur_rdata); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (cur_rdy !== 1'b1) begin errors++; $display("FAIL rm_idle_after got=%b want=1", cur_rdy); end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (cur_rv || !cur_cs) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rm_no_response got=%b want=0", seen); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        sel       = 0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 2'b00;
        req_wdata = 8'h00;
        rsp_ready = 1'b1;
        rd_val    = 8'h00;
        test_reset();
        test_write_ctrl();
        test_read_ports();
        test_backpressure();
        test_back_to_back();
        test_sweep();
        test_reset_mid();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drained got=%0d want=0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
